send_scheduler: RTL and testbench

- Sequences the single outbound serial link (the Sender datapath) among four requesters: ACK replies, game-lost notice, ready handshake and game-data updates.
- Issues one packet at a time and waits for link completion.
- Runs stop-and-wait on data, ready and lost packets: tracks the 1-bit sequence number, times out and retransmits on a missing ACK.
- Sits between the game/sender FSMs and the Sender packetiser, replacing the ad-hoc OR-ing of ready and ACK send requests.

---
 rtl/send_scheduler.sv | 270 +++++++++++++++++++++++++++
 tb/tb_send_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/send_scheduler.sv
// send_scheduler
//   Arbitrates the single outbound serial link among four requesters
//   (ACK > LOST > READY > DATA). It issues one packet at a time and runs
//   1-bit stop-and-wait with timeout/retransmit on DATA, READY and LOST packets.
//   Optional build macro SEND_SCHED_STATS_EN adds the saturating counters
//   pkts_sent_cnt and retrans_cnt.
module send_scheduler #(
    parameter int unsigned ACK_TIMEOUT_CYCLES = 20000,
    parameter int unsigned MAX_RETRIES        = 4,
    parameter int unsigned TMO_W              = 16
) (
    input  logic       clk,
    input  logic       rst_l,
    input  logic       ack_req,
    input  logic       ack_req_seq,
    input  logic       lost_req,
    input  logic       ready_req,
    input  logic       data_req,
    input  logic       ack_received,
    input  logic       ack_seq,
    input  logic       link_done,
    output logic       pkt_start,
    output logic [1:0] pkt_type,
    output logic       pkt_seq,
    output logic       busy,
    output logic       link_error,
    output logic [2:0] retry_cnt
`ifdef SEND_SCHED_STATS_EN
    ,
    output logic [7:0] pkts_sent_cnt,
    output logic [7:0] retrans_cnt
`endif
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_ACK,
        S_SEND_ACK_IN_WAIT
    } state_e;

    typedef enum logic [1:0] {
        PT_DATA  = 2'd0,
        PT_ACK   = 2'd1,
        PT_READY = 2'd2,
        PT_LOST  = 2'd3
    } pkt_type_e;

    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(ACK_TIMEOUT_CYCLES - 1);
    localparam logic [2:0]       RETRY_MAX = 3'(MAX_RETRIES);

    state_e          state_q, state_d;
    pkt_type_e       type_q, type_d;
    pkt_type_e       cur_type_q, cur_type_d;
    logic            start_q, start_d;
    logic            seq_q, seq_d;
    logic            tx_seq_q, tx_seq_d;
    logic [2:0]      retry_q, retry_d;
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic            err_q, err_d;
    logic            got_ack_q, got_ack_d;

    logic            ack_pend_q, ack_pend_seq_q;
    logic            lost_pend_q, ready_pend_q, data_pend_q;
    logic            lost_lvl_q, ready_lvl_q;

    logic            lost_rise, ready_rise;
    logic            ack_eff, ack_seq_eff, lost_eff, ready_eff, data_eff;
    logic            ack_match;
    logic            take_ack, take_lost, take_ready, take_data;

    // Requests seen this cycle count as pending, giving one-cycle latency from
    // request to pkt_start; a LOST edge supersedes any queued READY.
    assign lost_rise   = lost_req & ~lost_lvl_q;
    assign ready_rise  = ready_req & ~ready_lvl_q;
    assign ack_eff     = ack_pend_q | ack_req;
    assign ack_seq_eff = ack_req ? ack_req_seq : ack_pend_seq_q;
    assign lost_eff    = lost_pend_q | lost_rise;
    assign ready_eff   = (ready_pend_q | ready_rise) & ~lost_rise;
    assign data_eff    = data_pend_q | data_req;
    assign ack_match   = ack_received & (ack_seq == tx_seq_q);

    assign pkt_start  = start_q;
    assign pkt_type   = type_q;
    assign pkt_seq    = seq_q;
    assign busy       = (state_q != S_IDLE);
    assign link_error = err_q;
    assign retry_cnt  = retry_q;

    // Next-state, next-output and stop-and-wait bookkeeping
    always_comb begin
        state_d    = state_q;
        start_d    = 1'b0;
        type_d     = type_q;
        seq_d      = seq_q;
        cur_type_d = cur_type_q;
        tx_seq_d   = tx_seq_q;
        retry_d    = retry_q;
        tmo_d      = tmo_q;
        err_d      = err_q;
        got_ack_d  = got_ack_q;
        take_ack   = 1'b0;
        take_lost  = 1'b0;
        take_ready = 1'b0;
        take_data  = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (ack_eff) begin
                    start_d  = 1'b1;
                    type_d   = PT_ACK;
                    seq_d    = ack_seq_eff;
                    take_ack = 1'b1;
                    state_d  = S_SEND;
                end else if (lost_eff) begin
                    start_d    = 1'b1;
                    type_d     = PT_LOST;
                    cur_type_d = PT_LOST;
                    seq_d      = tx_seq_q;
                    take_lost  = 1'b1;
                    state_d    = S_SEND;
                end else if (ready_eff) begin
                    start_d    = 1'b1;
                    type_d     = PT_READY;
                    cur_type_d = PT_READY;
                    seq_d      = tx_seq_q;
                    take_ready = 1'b1;
                    state_d    = S_SEND;
                end else if (data_eff) begin
                    start_d    = 1'b1;
                    type_d     = PT_DATA;
                    cur_type_d = PT_DATA;
                    seq_d      = tx_seq_q;
                    take_data  = 1'b1;
                    state_d    = S_SEND;
                end
            end
            S_SEND: begin
                if (link_done) begin
                    if (type_q == PT_ACK) begin
                        state_d = S_IDLE;
                    end else begin
                        tmo_d   = '0;
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (ack_match) begin
                    tx_seq_d = ~tx_seq_q;
                    retry_d  = '0;
                    state_d  = S_IDLE;
                end else if (ack_eff) begin
                    // Timeout counter is left untouched so it resumes afterwards
                    start_d   = 1'b1;
                    type_d    = PT_ACK;
                    seq_d     = ack_seq_eff;
                    take_ack  = 1'b1;
                    got_ack_d = 1'b0;
                    state_d   = S_SEND_ACK_IN_WAIT;
                end else if (tmo_q == TMO_LAST) begin
                    if (retry_q < RETRY_MAX) begin
                        retry_d = retry_q + 3'd1;
                        start_d = 1'b1;
                        type_d  = cur_type_q;
                        seq_d   = tx_seq_q;
                        state_d = S_SEND;
                    end else begin
                        err_d   = 1'b1;
                        retry_d = '0;
                        state_d = S_IDLE;
                    end
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            S_SEND_ACK_IN_WAIT: begin
                // An ACK for our own packet may land while our ACK reply is
                // still shifting out; remember it instead of losing it.
                if (ack_match) begin
                    got_ack_d = 1'b1;
                end
                if (link_done) begin
                    if (got_ack_q || ack_match) begin
                        tx_seq_d  = ~tx_seq_q;
                        retry_d   = '0;
                        got_ack_d = 1'b0;
                        state_d   = S_IDLE;
                    end else begin
                        state_d = S_WAIT_ACK;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // FSM state and registered packet outputs
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            state_q    <= S_IDLE;
            start_q    <= 1'b0;
            type_q     <= PT_DATA;
            seq_q      <= 1'b0;
            cur_type_q <= PT_DATA;
            tx_seq_q   <= 1'b0;
            retry_q    <= '0;
            tmo_q      <= '0;
            err_q      <= 1'b0;
            got_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            start_q    <= start_d;
            type_q     <= type_d;
            seq_q      <= seq_d;
            cur_type_q <= cur_type_d;
            tx_seq_q   <= tx_seq_d;
            retry_q    <= retry_d;
            tmo_q      <= tmo_d;
            err_q      <= err_d;
            got_ack_q  <= got_ack_d;
        end
    end

    // Pending request flags and level-input edge history
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            ack_pend_q     <= 1'b0;
            ack_pend_seq_q <= 1'b0;
            lost_pend_q    <= 1'b0;
            ready_pend_q   <= 1'b0;
            data_pend_q    <= 1'b0;
            lost_lvl_q     <= 1'b0;
            ready_lvl_q    <= 1'b0;
        end else begin
            ack_pend_q     <= ack_eff & ~take_ack;
            ack_pend_seq_q <= ack_seq_eff;
            lost_pend_q    <= lost_eff & ~take_lost;
            ready_pend_q   <= ready_eff & ~take_ready;
            data_pend_q    <= data_eff & ~take_data;
            lost_lvl_q     <= lost_req;
            ready_lvl_q    <= ready_req;
        end
    end

`ifdef SEND_SCHED_STATS_EN
    logic [7:0] sent_q, retrans_q;
    logic       retrans_evt;

    // A non-ACK launch from WAIT_ACK can only be a timeout re-issue
    assign retrans_evt   = start_d && (state_q == S_WAIT_ACK) && (type_d != PT_ACK);
    assign pkts_sent_cnt = sent_q;
    assign retrans_cnt   = retrans_q;

    // Saturating packet and retransmission counters
    always_ff @(posedge clk or negedge rst_l) begin
        if (!rst_l) begin
            sent_q    <= '0;
            retrans_q <= '0;
        end else begin
            if (start_d && (sent_q != 8'hFF)) begin
                sent_q <= sent_q + 8'd1;
            end
            if (retrans_evt && (retrans_q != 8'hFF)) begin
                retrans_q <= retrans_q + 8'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_send_scheduler.sv
// tb_send_scheduler: directed self-checking bench for send_scheduler
// (ACK_TIMEOUT_CYCLES=16, MAX_RETRIES=2).
module tb_send_scheduler;

    logic       clk = 1'b0;
    logic       rst_l = 1'b0;
    logic       ack_req = 1'b0, ack_req_seq = 1'b0, lost_req = 1'b0, ready_req = 1'b0;
    logic       data_req = 1'b0, ack_received = 1'b0, ack_seq = 1'b0, link_done = 1'b0;
    logic       pkt_start, pkt_seq, busy, link_error;
    logic [1:0] pkt_type;
    logic [2:0] retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    send_scheduler #(
        .ACK_TIMEOUT_CYCLES(16),
        .MAX_RETRIES(2),
        .TMO_W(16)
    ) dut (
        .clk(clk), .rst_l(rst_l),
        .ack_req(ack_req), .ack_req_seq(ack_req_seq),
        .lost_req(lost_req), .ready_req(ready_req), .data_req(data_req),
        .ack_received(ack_received), .ack_seq(ack_seq), .link_done(link_done),
        .pkt_start(pkt_start), .pkt_type(pkt_type), .pkt_seq(pkt_seq),
        .busy(busy), .link_error(link_error), .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_link_done();
        link_done = 1'b1; step(); link_done = 1'b0;
    endtask

    task automatic pulse_ack(input logic s);
        ack_received = 1'b1; ack_seq = s; step(); ack_received = 1'b0;
    endtask

    task automatic pulse_data();
        data_req = 1'b1; step(); data_req = 1'b0;
    endtask

    // Steps until pkt_start is seen or max steps elapse; n = steps taken
    task automatic wait_start(input int max, output int n);
        n = 0;
        while (!pkt_start && n < max) begin
            step();
            n++;
        end
    endtask

    task automatic test_reset();
        rst_l = 1'b0;
        repeat (3) step();
        n_checks++; if (pkt_start !== 1'b0) begin n_fail++; $display("FAIL rst_start: got %b expected 0", pkt_start); end
        n_checks++; if (pkt_type !== 2'd0) begin n_fail++; $display("FAIL rst_type: got %0d expected 0", pkt_type); end
        n_checks++; if (pkt_seq !== 1'b0) begin n_fail++; $display("FAIL rst_seq: got %b expected 0", pkt_seq); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b expected 0", busy); end
        n_checks++; if (link_error !== 1'b0) begin n_fail++; $display("FAIL rst_err: got %b expected 0", link_error); end
        n_checks++; if (retry_cnt !== 3'd0) begin n_fail++; $display("FAIL rst_retry: got %0d expected 0", retry_cnt); end
        rst_l = 1'b1;
        step();
    endtask

    task automatic test_priority();
        ack_req = 1'b1; ack_req_seq = 1'b1; data_req = 1'b1; ready_req = 1'b1;
        step();
        ack_req = 1'b0; data_req = 1'b0;
        n_checks++; if (pkt_start !== 1'b1) begin n_fail++; $display("FAIL prio_ack_start: got %b expected 1", pkt_start); end
        n_checks++; if (pkt_type !== 2'd1) begin n_fail++; $display("FAIL prio_ack_type: got %0d expected 1", pkt_type); end
        n_checks++; if (pkt_seq !== 1'b1) begin n_fail++; $display("FAIL prio_ack_seq: got %b expected 1", pkt_seq); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prio_busy: got %b expected 1", busy); end
        step();
        n_checks++; if (pkt_start !== 1'b0) begin n_fail++; $display("FAIL prio_start_one_cycle: got %b expected 0", pkt_start); end
        pulse_link_done();
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_ack_done_idle: got %b expected 0", busy); end
        step();
        n_checks++; if (pkt_start !== 1'b1) begin n_fail++; $display("FAIL prio_ready_start: got %b expected 1", pkt_start); end
        n_checks++; if (pkt_type !== 2'd2) begin n_fail++; $display("FAIL prio_ready_type: got %0d expected 2", pkt_type); end
        n_checks++; if (pkt_seq !== 1'b0) begin n_fail++; $display("FAIL prio_ready_seq: got %b expected 0", pkt_seq); end
        pulse_link_done();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL prio_wait_busy: got %b expected 1", busy); end
        pulse_ack(1'b0);
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL prio_acked_idle: got %b expected 0", busy); end
        step();
        n_checks++; if (pkt_start !== 1'b1) begin n_fail++; $display("FAIL prio_data_start: got %b expected 1", pkt_start); end
        n_checks++; if (pkt_type !== 2'd0) begin n_fail++; $display("FAIL prio_data_type: got %0d expected 0", pkt_type); end
        n_checks++; if (pkt_seq !== 1'b1) begin n_fail++; $display("FAIL prio_data_seq: got %b expected 1", pkt_seq); end
        pulse_link_done();
        pulse_ack(1'b1);
        ready_req = 1'b0;
        step();
    endtask

    task automatic test_timeout_retry();
        int n;
        pulse_data();
        n_checks++; if (pkt_start !== 1'b1 || pkt_seq !== 1'b0) begin n_fail++; $display("FAIL tmo_first: got start=%b seq=%b expected 1/0", pkt_start, pkt_seq); end
        for (int r = 1; r <= 2; r++) begin
            pulse_link_done();
            wait_start(40, n);
            n_checks++; if (n !== 16) begin n_fail++; $display("FAIL tmo_gap%0d: got %0d cycles expected 16", r, n); end
            n_checks++; if (pkt_seq !== 1'b0 || pkt_type !== 2'd0) begin n_fail++; $display("FAIL tmo_reissue%0d: got seq=%b type=%0d expected 0/0", r, pkt_seq, pkt_type); end
            n_checks++; if (retry_cnt !== 3'(r)) begin n_fail++; $display("FAIL tmo_retry%0d: got %0d expected %0d", r, retry_cnt, r); end
        end
        pulse_link_done();
        repeat (15) step();
        n_checks++; if (link_error !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL tmo_pre_err: got err=%b busy=%b expected 0/1", link_error, busy); end
        step();
        n_checks++; if (link_error !== 1'b1) begin n_fail++; $display("FAIL tmo_err: got %b expected 1", link_error); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_err_idle: got %b expected 0", busy); end
        n_checks++; if (retry_cnt !== 3'd0) begin n_fail++; $display("FAIL tmo_err_retry: got %0d expected 0", retry_cnt); end
        n_checks++; if (pkt_start !== 1'b0) begin n_fail++; $display("FAIL tmo_no_4th: got %b expected 0", pkt_start); end
    endtask

    task automatic test_wrong_seq();
        int n;
        pulse_data();
        n_checks++; if (pkt_start !== 1'b1 || pkt_seq !== 1'b0) begin n_fail++; $display("FAIL wseq_txseq_kept: got start=%b seq=%b expected 1/0", pkt_start, pkt_seq); end
        pulse_link_done();
        repeat (3) step();
        pulse_ack(1'b1);
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL wseq_still_wait: got %b expected 1", busy); end
        wait_start(30, n);
        n_checks++; if (n !== 12) begin n_fail++; $display("FAIL wseq_timeout: got %0d cycles expected 12", n); end
        n_checks++; if (retry_cnt !== 3'd1 || pkt_seq !== 1'b0) begin n_fail++; $display("FAIL wseq_reissue: got retry=%0d seq=%b expected 1/0", retry_cnt, pkt_seq); end
        n_checks++; if (link_error !== 1'b1) begin n_fail++; $display("FAIL wseq_err_sticky: got %b expected 1", link_error); end
        pulse_link_done();
        pulse_ack(1'b0);
        n_checks++; if (busy !== 1'b0 || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL wseq_acked: got busy=%b retry=%0d expected 0/0", busy, retry_cnt); end
    endtask

    task automatic test_ack_during_wait();
        int n;
        pulse_data();
        n_checks++; if (pkt_start !== 1'b1 || pkt_seq !== 1'b1) begin n_fail++; $display("FAIL aw_data: got start=%b seq=%b expected 1/1", pkt_start, pkt_seq); end
        pulse_link_done();
        repeat (5) step();
        ack_req = 1'b1; ack_req_seq = 1'b0; step(); ack_req = 1'b0;
        n_checks++; if (pkt_start !== 1'b1 || pkt_type !== 2'd1 || pkt_seq !== 1'b0) begin n_fail++; $display("FAIL aw_ack_out: got start=%b type=%0d seq=%b expected 1/1/0", pkt_start, pkt_type, pkt_seq); end
        pulse_link_done();
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL aw_back_wait: got %b expected 1", busy); end
        wait_start(30, n);
        n_checks++; if (n !== 11) begin n_fail++; $display("FAIL aw_tmo_resume: got %0d cycles expected 11", n); end
        n_checks++; if (pkt_type !== 2'd0 || pkt_seq !== 1'b1 || retry_cnt !== 3'd1) begin n_fail++; $display("FAIL aw_reissue: got type=%0d seq=%b retry=%0d expected 0/1/1", pkt_type, pkt_seq, retry_cnt); end
        pulse_link_done();
        pulse_ack(1'b1);
    endtask

    task automatic test_ack_at_timeout();
        pulse_data();
        n_checks++; if (pkt_seq !== 1'b0) begin n_fail++; $display("FAIL at_data_seq: got %b expected 0", pkt_seq); end
        pulse_link_done();
        repeat (15) step();
        ack_received = 1'b1; ack_seq = 1'b0; ack_req = 1'b1; ack_req_seq = 1'b1;
        step();
        ack_received = 1'b0; ack_req = 1'b0;
        n_checks++; if (busy !== 1'b0 || pkt_start !== 1'b0 || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL at_ack_wins: got busy=%b start=%b retry=%0d expected 0/0/0", busy, pkt_start, retry_cnt); end
        step();
        n_checks++; if (pkt_start !== 1'b1 || pkt_type !== 2'd1 || pkt_seq !== 1'b1) begin n_fail++; $display("FAIL at_pending_ack: got start=%b type=%0d seq=%b expected 1/1/1", pkt_start, pkt_type, pkt_seq); end
        pulse_link_done();
    endtask

    task automatic test_coalescing();
        int n;
        pulse_data();
        n_checks++; if (pkt_start !== 1'b1 || pkt_seq !== 1'b1) begin n_fail++; $display("FAIL coal_first: got start=%b seq=%b expected 1/1", pkt_start, pkt_seq); end
        repeat (3) begin pulse_data(); step(); end
        pulse_link_done();
        pulse_ack(1'b1);
        step();
        n_checks++; if (pkt_start !== 1'b1 || pkt_type !== 2'd0 || pkt_seq !== 1'b0) begin n_fail++; $display("FAIL coal_one: got start=%b type=%0d seq=%b expected 1/0/0", pkt_start, pkt_type, pkt_seq); end
        pulse_link_done();
        pulse_ack(1'b0);
        pulse_link_done();
        wait_start(10, n);
        n_checks++; if (pkt_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL coal_no_extra: got start=%b busy=%b expected 0/0", pkt_start, busy); end
    endtask

    task automatic test_lost_supersedes();
        int n;
        pulse_data();
        ready_req = 1'b1; step();
        lost_req = 1'b1; step();
        pulse_link_done();
        pulse_ack(1'b1);
        step();
        n_checks++; if (pkt_start !== 1'b1 || pkt_type !== 2'd3 || pkt_seq !== 1'b0) begin n_fail++; $display("FAIL lost_pkt: got start=%b type=%0d seq=%b expected 1/3/0", pkt_start, pkt_type, pkt_seq); end
        pulse_link_done();
        pulse_ack(1'b0);
        wait_start(10, n);
        n_checks++; if (pkt_start !== 1'b0) begin n_fail++; $display("FAIL lost_ready_dropped: got %b expected 0", pkt_start); end
        ready_req = 1'b0; lost_req = 1'b0;
        step();
    endtask

    task automatic test_reset_mid_send();
        int n;
        ack_req = 1'b1; ack_req_seq = 1'b1; data_req = 1'b1;
        step();
        ack_req = 1'b0; data_req = 1'b0;
        n_checks++; if (pkt_start !== 1'b1 || pkt_type !== 2'd1 || pkt_seq !== 1'b1 || link_error !== 1'b1) begin n_fail++; $display("FAIL rms_pre: got start=%b type=%0d seq=%b err=%b expected 1/1/1/1", pkt_start, pkt_type, pkt_seq, link_error); end
        rst_l = 1'b0;
        #1;
        n_checks++; if (pkt_start !== 1'b0 || pkt_type !== 2'd0 || pkt_seq !== 1'b0) begin n_fail++; $display("FAIL rms_pkt: got start=%b type=%0d seq=%b expected 0/0/0", pkt_start, pkt_type, pkt_seq); end
        n_checks++; if (busy !== 1'b0 || link_error !== 1'b0 || retry_cnt !== 3'd0) begin n_fail++; $display("FAIL rms_status: got busy=%b err=%b retry=%0d expected 0/0/0", busy, link_error, retry_cnt); end
        step();
        rst_l = 1'b1;
        wait_start(10, n);
        n_checks++; if (pkt_start !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL rms_no_start: got start=%b busy=%b expected 0/0", pkt_start, busy); end
    endtask

    initial begin
        test_reset();
        test_priority();
        test_timeout_retry();
        test_wrong_seq();
        test_ack_during_wait();
        test_ack_at_timeout();
        test_coalescing();
        test_lost_supersedes();
        test_reset_mid_send();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
